// File: rtl/deserializer.sv
// Serial-to-parallel receiver: collects an MSB-first bit stream qualified by a
// valid strobe and emits a left-aligned word plus its bit count.
module deserializer #(
    parameter int DATA_BUS_WIDTH = 16,
    parameter int DATA_MOD_WIDTH = 4
) (
    input  logic                      clk_i,
    input  logic                      srst_i,
    input  logic                      ser_data_i,
    input  logic                      ser_data_val_i,
    output logic [DATA_BUS_WIDTH-1:0] deser_data_o,
    output logic [DATA_MOD_WIDTH-1:0] deser_data_mod_o,
    output logic                      deser_data_val_o,
    output logic                      busy_o,
    output logic                      frame_err_o
);

    localparam int CNT_W = DATA_MOD_WIDTH + 1;

    typedef enum logic {
        IDLE_S,
        RECV_S
    } state_t;

    state_t                    state_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [CNT_W-1:0]          cnt_d;
    logic [DATA_BUS_WIDTH-1:0] buf_q;
    logic [DATA_BUS_WIDTH-1:0] buf_d;
    logic [DATA_BUS_WIDTH-1:0] data_q;
    logic [DATA_MOD_WIDTH-1:0] mod_q;
    logic                      val_q;
    logic                      busy_q;
    logic                      err_q;

    assign cnt_d = cnt_q + CNT_W'(1);

    // Buffer with the incoming bit dropped into slot W-1-count; the counter is
    // zero in IDLE_S, so the first bit lands in the MSB without special casing.
    generate
        for (genvar gi = 0; gi < DATA_BUS_WIDTH; gi++) begin : g_insert
            assign buf_d[gi] = (cnt_q == CNT_W'(DATA_BUS_WIDTH - 1 - gi)) ?
                               ser_data_i : buf_q[gi];
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (!srst_i) begin
            state_q <= IDLE_S;
            cnt_q   <= '0;
            buf_q   <= '0;
            data_q  <= '0;
            mod_q   <= '0;
            val_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            val_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                IDLE_S: begin
                    if (ser_data_val_i) begin
                        buf_q   <= buf_d;
                        cnt_q   <= cnt_d;
                        state_q <= RECV_S;
                        busy_q  <= 1'b1;
                    end
                end
                RECV_S: begin
                    if (ser_data_val_i) begin
                        if (cnt_d == CNT_W'(DATA_BUS_WIDTH)) begin
                            data_q  <= buf_d;
                            mod_q   <= '0;
                            val_q   <= 1'b1;
                            cnt_q   <= '0;
                            buf_q   <= '0;
                            state_q <= IDLE_S;
                            busy_q  <= 1'b0;
                        end else begin
                            buf_q <= buf_d;
                            cnt_q <= cnt_d;
                        end
                    end else begin
                        // 1- and 2-bit frames are never sent by the transmitter: flag them.
                        if (cnt_q >= CNT_W'(3)) begin
                            data_q <= buf_q;
                            mod_q  <= cnt_q[DATA_MOD_WIDTH-1:0];
                            val_q  <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                        cnt_q   <= '0;
                        buf_q   <= '0;
                        state_q <= IDLE_S;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    buf_q   <= '0;
                    state_q <= IDLE_S;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign deser_data_o     = data_q;
    assign deser_data_mod_o = mod_q;
    assign deser_data_val_o = val_q;
    assign busy_o           = busy_q;
    assign frame_err_o      = err_q;

endmodule

// File: tb/tb_deserializer.sv
// Directed and randomised checks of the deserializer with hand-computed words.
module tb_deserializer;

    localparam int W  = 16;
    localparam int MW = 4;

    logic          clk_i = 1'b0;
    logic          srst_i = 1'b0;
    logic          ser_data_i = 1'b0;
    logic          ser_data_val_i = 1'b0;
    logic [W-1:0]  deser_data_o;
    logic [MW-1:0] deser_data_mod_o;
    logic          deser_data_val_o;
    logic          busy_o;
    logic          frame_err_o;

    int n_vec = 0;
    int n_err = 0;
    int err_pulses = 0;

    deserializer #(
        .DATA_BUS_WIDTH(W),
        .DATA_MOD_WIDTH(MW)
    ) dut (
        .clk_i           (clk_i),
        .srst_i          (srst_i),
        .ser_data_i      (ser_data_i),
        .ser_data_val_i  (ser_data_val_i),
        .deser_data_o    (deser_data_o),
        .deser_data_mod_o(deser_data_mod_o),
        .deser_data_val_o(deser_data_val_o),
        .busy_o          (busy_o),
        .frame_err_o     (frame_err_o)
    );

    always #5 clk_i = ~clk_i;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
        if (frame_err_o) err_pulses++;
    endtask

    task automatic send_bit(input logic b);
        ser_data_val_i = 1'b1;
        ser_data_i     = b;
        tick();
    endtask

    task automatic idle_cycle();
        ser_data_val_i = 1'b0;
        ser_data_i     = 1'($urandom_range(0, 1));
        tick();
    endtask

    task automatic test_reset();
        srst_i = 1'b0;
        ser_data_val_i = 1'b1;
        ser_data_i = 1'b1;
        tick();
        tick();
        n_vec++;
        if ({deser_data_o, deser_data_mod_o, deser_data_val_o, busy_o, frame_err_o} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got data=%h mod=%0d val=%b busy=%b err=%b, want all 0",
                     deser_data_o, deser_data_mod_o, deser_data_val_o, busy_o, frame_err_o);
        end
        ser_data_val_i = 1'b0;
        srst_i = 1'b1;
        tick();
        $display("reset: outputs held at zero");
    endtask

    task automatic test_full_word();
        logic [W-1:0] w;
        w = 16'hA5C3;
        for (int i = 0; i < W; i++) begin
            send_bit(w[W-1-i]);
            if (i < W - 1) begin
                n_vec++;
                if (busy_o !== 1'b1 || deser_data_val_o !== 1'b0) begin
                    n_err++;
                    $display("FAIL full_busy bit %0d: got busy=%b val=%b, want busy=1 val=0",
                             i + 2, busy_o, deser_data_val_o);
                end
            end
        end
        n_vec++;
        if (deser_data_val_o !== 1'b1 || deser_data_o !== 16'hA5C3 ||
            deser_data_mod_o !== 4'd0 || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL full_word: got val=%b data=%h mod=%0d busy=%b, want 1 a5c3 0 0",
                     deser_data_val_o, deser_data_o, deser_data_mod_o, busy_o);
        end
        idle_cycle();
        n_vec++;
        if (deser_data_val_o !== 1'b0 || deser_data_o !== 16'hA5C3) begin
            n_err++;
            $display("FAIL full_hold: got val=%b data=%h, want 0 a5c3",
                     deser_data_val_o, deser_data_o);
        end
        $display("full word: sent a5c3 (16 bits)");
    endtask

    task automatic test_short_frame();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        n_vec++;
        if (deser_data_val_o !== 1'b0) begin
            n_err++;
            $display("FAIL short_early: got val=%b one cycle after last bit, want 0", deser_data_val_o);
        end
        idle_cycle();
        n_vec++;
        if (deser_data_val_o !== 1'b1 || deser_data_o !== 16'hB000 ||
            deser_data_mod_o !== 4'd5 || frame_err_o !== 1'b0) begin
            n_err++;
            $display("FAIL short_word: got val=%b data=%h mod=%0d err=%b, want 1 b000 5 0",
                     deser_data_val_o, deser_data_o, deser_data_mod_o, frame_err_o);
        end
        idle_cycle();
        n_vec++;
        if (deser_data_val_o !== 1'b0 || frame_err_o !== 1'b0) begin
            n_err++;
            $display("FAIL short_single_pulse: got val=%b err=%b, want 0 0",
                     deser_data_val_o, frame_err_o);
        end
        $display("short frame: sent 10110 (5 bits)");
    endtask

    task automatic test_runt();
        send_bit(1'b1); send_bit(1'b1);
        idle_cycle();
        n_vec++;
        if (frame_err_o !== 1'b1 || deser_data_val_o !== 1'b0 || deser_data_o !== 16'hB000) begin
            n_err++;
            $display("FAIL runt: got err=%b val=%b data=%h, want 1 0 b000",
                     frame_err_o, deser_data_val_o, deser_data_o);
        end
        idle_cycle();
        n_vec++;
        if (frame_err_o !== 1'b0 || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL runt_single_pulse: got err=%b busy=%b, want 0 0", frame_err_o, busy_o);
        end
        $display("runt frame: sent 11 (2 bits)");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < W; i++) send_bit(1'b1);
        n_vec++;
        if (deser_data_val_o !== 1'b1 || deser_data_o !== 16'hFFFF || deser_data_mod_o !== 4'd0) begin
            n_err++;
            $display("FAIL b2b_first: got val=%b data=%h mod=%0d, want 1 ffff 0",
                     deser_data_val_o, deser_data_o, deser_data_mod_o);
        end
        send_bit(1'b1);
        n_vec++;
        if (deser_data_val_o !== 1'b0 || busy_o !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_restart: got val=%b busy=%b, want 0 1", deser_data_val_o, busy_o);
        end
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        idle_cycle();
        n_vec++;
        if (deser_data_val_o !== 1'b1 || deser_data_o !== 16'hA000 || deser_data_mod_o !== 4'd4) begin
            n_err++;
            $display("FAIL b2b_second: got val=%b data=%h mod=%0d, want 1 a000 4",
                     deser_data_val_o, deser_data_o, deser_data_mod_o);
        end
        idle_cycle();
        $display("back to back: sent ffff then 1010 (20 bits)");
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        srst_i = 1'b0;
        ser_data_val_i = 1'b0;
        tick();
        n_vec++;
        if (deser_data_val_o !== 1'b0 || busy_o !== 1'b0 || frame_err_o !== 1'b0 ||
            deser_data_o !== '0 || deser_data_mod_o !== '0) begin
            n_err++;
            $display("FAIL mid_reset: got val=%b busy=%b err=%b data=%h mod=%0d, want all 0",
                     deser_data_val_o, busy_o, frame_err_o, deser_data_o, deser_data_mod_o);
        end
        srst_i = 1'b1;
        idle_cycle();
        n_vec++;
        if (deser_data_val_o !== 1'b0 || frame_err_o !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset_quiet: got val=%b err=%b, want 0 0", deser_data_val_o, frame_err_o);
        end
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        idle_cycle();
        n_vec++;
        if (deser_data_val_o !== 1'b1 || deser_data_o !== 16'hE000 || deser_data_mod_o !== 4'd3) begin
            n_err++;
            $display("FAIL post_reset_word: got val=%b data=%h mod=%0d, want 1 e000 3",
                     deser_data_val_o, deser_data_o, deser_data_mod_o);
        end
        idle_cycle();
        $display("mid-frame reset: 7 bits dropped, then 111 (3 bits)");
    endtask

    task automatic test_random_frames();
        int           len;
        int           gap;
        logic         b;
        logic [W-1:0] word;
        logic [MW-1:0] mod;
        err_pulses = 0;
        for (int f = 0; f < 40; f++) begin
            len  = $urandom_range(3, W);
            word = '0;
            for (int i = 0; i < len; i++) begin
                b    = 1'($urandom_range(0, 1));
                word = word | (W'(b) << (W - 1 - i));
                send_bit(b);
            end
            mod = MW'(len);
            gap = $urandom_range(1, 3);
            // A full word strobes right after its last bit; shorter ones after the first idle cycle.
            for (int g = 0; g <= gap; g++) begin
                if ((len == W && g == 0) || (len < W && g == 1)) begin
                    n_vec++;
                    if (deser_data_val_o !== 1'b1 || deser_data_o !== word || deser_data_mod_o !== mod) begin
                        n_err++;
                        $display("FAIL random frame %0d: got val=%b data=%h mod=%0d, want 1 %h %0d",
                                 f, deser_data_val_o, deser_data_o, deser_data_mod_o, word, mod);
                    end
                end
                if (g < gap) idle_cycle();
            end
            $display("random frame %0d: len=%0d word=%h gap=%0d", f, len, word, gap);
        end
        n_vec++;
        if (err_pulses != 0) begin
            n_err++;
            $display("FAIL random_frame_err: got %0d frame_err pulses, want 0", err_pulses);
        end
    endtask

    initial begin
        void'($urandom(32'd1234));
        test_reset();
        test_full_word();
        test_short_frame();
        test_runt();
        test_back_to_back();
        test_mid_reset();
        test_random_frames();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/deserializer.md
Name: deserializer

Overview:
- Receive-side counterpart of the team's serializer.
- Samples a serial bit stream, MSB first, qualified by a valid strobe, and rebuilds the parallel word together with its bit count (data_mod).
- Sits at the far end of the serial link and hands left-aligned words to the parallel datapath.
- No backpressure: it keeps up with one bit per clock, indefinitely.

Parameters:
- DATA_BUS_WIDTH, 16, width of the reassembled parallel word; max bits per frame.
- DATA_MOD_WIDTH, 4, width of data_mod; must be at least clog2(DATA_BUS_WIDTH).

Ports:
- clk_i  input  1  single clock; all logic on posedge.
- srst_i  input  1  synchronous reset, active-low (0 = reset).
- ser_data_i  input  1  serial data bit, MSB of the frame first.
- ser_data_val_i  input  1  high while ser_data_i carries a valid bit; a low cycle ends the frame.
- deser_data_o  output  DATA_BUS_WIDTH  reassembled word, left-aligned; unused LSBs are 0.
- deser_data_mod_o  output  DATA_MOD_WIDTH  number of valid bits; 0 means DATA_BUS_WIDTH bits.
- deser_data_val_o  output  1  one-cycle strobe; deser_data_o and deser_data_mod_o are valid in this cycle.
- busy_o  output  1  high while a frame is partially received.
- frame_err_o  output  1  one-cycle strobe when a runt frame (1 or 2 bits) is dropped.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Reset values (srst_i=0 sampled at posedge): state IDLE_S, bit counter 0, shift buffer 0, all outputs 0.
- States: IDLE_S (no bits held) and RECV_S (1..DATA_BUS_WIDTH-1 bits held).
- IDLE_S:
  - ser_data_val_i=1 at an edge: store the bit at index W-1, counter=1, go to RECV_S.
  - Otherwise stay in IDLE_S.
- RECV_S with ser_data_val_i=1:
  - Store the bit at index W-1-counter and increment the counter.
  - If that was bit number W: register the word, mod=0, strobe deser_data_val_o in the next cycle, clear counter and buffer, go to IDLE_S.
- RECV_S with ser_data_val_i=0 (frame end, N = counter):
  - N>=3: register the word, mod=N, strobe deser_data_val_o in the next cycle.
  - N=1 or 2: no data strobe; strobe frame_err_o in the next cycle. This matches the serializer never sending 1- or 2-bit frames.
  - In all cases, clear counter and buffer and go to IDLE_S.
- Latency:
  - Full-width frame: strobe appears one cycle after the last bit.
  - Short frame: strobe appears one cycle after the first val-low cycle, i.e. two cycles after the last bit.
- Back-to-back frames:
  - A valid bit arriving in the cycle right after a full-width frame completes starts a new frame. No bit is lost.
  - Streams longer than W bits therefore split into W-bit words plus a remainder.
- Output data:
  - deser_data_o and deser_data_mod_o are registered, update only on a strobe, and hold until the next strobe.
  - deser_data_val_o and frame_err_o are never high in the same cycle.
- busy_o: equals (state == RECV_S), registered.
- Reset mid-frame: the partial frame is discarded. No data or error strobe; all outputs return to 0.
- Counter width is DATA_MOD_WIDTH+1 internally so that the count W is representable. deser_data_mod_o is the low DATA_MOD_WIDTH bits of N, so N=W yields 0.
- Bit 0 of ser_data_i is don't-care while ser_data_val_i=0.

Test Plan:
1. 16 bits of 0xA5C3, MSB first, val high for 16 consecutive cycles -> one cycle after the last bit: deser_data_val_o=1 for one cycle, data=0xA5C3, mod=0; busy_o high during bits 2..16.
2. 5 bits 1,0,1,1,0 then val low -> two cycles after the last bit: data=0xB000, mod=5, val pulse; frame_err_o stays 0.
3. 2 bits 1,1 then val low -> frame_err_o pulses once; deser_data_val_o stays 0; deser_data_o keeps its previous value.
4. 20 consecutive valid bits (0xFFFF then 1,0,1,0) -> first strobe one cycle after bit 16 with data=0xFFFF, mod=0; second strobe two cycles after bit 20 with data=0xA000, mod=4.
5. srst_i=0 for one cycle after 7 bits of a frame -> no strobe; busy_o=0. A following 3-bit frame 1,1,1 yields data=0xE000, mod=3.
6. Random lengths 3..16 with random 1..3-cycle gaps, driven through the serializer, with scoreboard comparison -> every word and mod matches the serializer input, and there are zero frame_err_o pulses.
